// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use, I/D-cache miss waits,
// multiply occupancy and taken-branch squashes, plus a stall-cycle counter.
module pipeline_hazard_ctrl #(
    parameter int MUL_LATENCY = 4,
    parameter int REG_W       = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [REG_W-1:0] d_rs,
    input  logic [REG_W-1:0] d_rt,
    input  logic             d_uses_rs,
    input  logic             d_uses_rt,
    input  logic [REG_W-1:0] e_rd,
    input  logic             e_mem_read,
    input  logic             e_branch_taken,
    input  logic             e_mul_start,
    input  logic             icache_miss,
    input  logic             icache_ready,
    input  logic             dcache_miss,
    input  logic             dcache_ready,
    output logic             pc_hold,
    output logic             f_stall,
    output logic             d_hold,
    output logic             e_bubble,
    output logic             e_hold,
    output logic             m_bubble,
    output logic             icache_abort,
    output logic [1:0]       ctrl_state,
    output logic [31:0]      stall_count
);

    localparam int CNT_W = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY) : 1;
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 1);

    typedef enum logic [1:0] {
        S_RUN     = 2'd0,
        S_IWAIT   = 2'd1,
        S_DWAIT   = 2'd2,
        S_MULBUSY = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic [31:0]      stall_count_q, stall_count_d;

    logic load_use_s;
    logic pc_hold_s, f_stall_s, d_hold_s, e_bubble_s, e_hold_s, m_bubble_s, icache_abort_s;

    // Load in execute whose destination feeds a source the decode instruction reads
    always_comb begin
        load_use_s = e_mem_read && (e_rd != {REG_W{1'b0}}) &&
                     ((d_uses_rs && (d_rs == e_rd)) || (d_uses_rt && (d_rt == e_rd)));
    end

    // Next-state and control decode; a transition shows the destination state's controls
    always_comb begin
        state_d        = state_q;
        mul_cnt_d      = mul_cnt_q;
        pc_hold_s      = 1'b0;
        f_stall_s      = 1'b0;
        d_hold_s       = 1'b0;
        e_bubble_s     = 1'b0;
        e_hold_s       = 1'b0;
        m_bubble_s     = 1'b0;
        icache_abort_s = 1'b0;
        case (state_q)
            S_RUN: begin
                if (dcache_miss) begin
                    state_d    = S_DWAIT;
                    pc_hold_s  = 1'b1;
                    d_hold_s   = 1'b1;
                    e_hold_s   = 1'b1;
                    m_bubble_s = 1'b1;
                end else if (e_mul_start) begin
                    state_d    = S_MULBUSY;
                    mul_cnt_d  = MUL_LOAD;
                    pc_hold_s  = 1'b1;
                    d_hold_s   = 1'b1;
                    e_hold_s   = 1'b1;
                    m_bubble_s = 1'b1;
                end else if (e_branch_taken) begin
                    // Redirect wins over a fetch miss: the missing line is on the wrong path
                    f_stall_s      = 1'b1;
                    e_bubble_s     = 1'b1;
                    icache_abort_s = icache_miss;
                end else if (icache_miss) begin
                    state_d   = S_IWAIT;
                    pc_hold_s = 1'b1;
                    f_stall_s = 1'b1;
                end else if (load_use_s) begin
                    pc_hold_s  = 1'b1;
                    d_hold_s   = 1'b1;
                    e_bubble_s = 1'b1;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_IWAIT: begin
                if (dcache_miss) begin
                    state_d    = S_DWAIT;
                    pc_hold_s  = 1'b1;
                    d_hold_s   = 1'b1;
                    e_hold_s   = 1'b1;
                    m_bubble_s = 1'b1;
                end else if (e_branch_taken) begin
                    state_d        = S_RUN;
                    icache_abort_s = 1'b1;
                    f_stall_s      = 1'b1;
                    e_bubble_s     = 1'b1;
                end else if (icache_ready) begin
                    state_d = S_RUN;
                end else begin
                    pc_hold_s = 1'b1;
                    f_stall_s = 1'b1;
                end
            end
            S_DWAIT: begin
                if (dcache_ready) begin
                    state_d = S_RUN;
                end else begin
                    pc_hold_s  = 1'b1;
                    d_hold_s   = 1'b1;
                    e_hold_s   = 1'b1;
                    m_bubble_s = 1'b1;
                end
            end
            S_MULBUSY: begin
                if (mul_cnt_q == {CNT_W{1'b0}}) begin
                    state_d = S_RUN;
                end else begin
                    mul_cnt_d  = mul_cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                    pc_hold_s  = 1'b1;
                    d_hold_s   = 1'b1;
                    e_hold_s   = 1'b1;
                    m_bubble_s = 1'b1;
                end
            end
            default: begin
                state_d   = S_RUN;
                mul_cnt_d = {CNT_W{1'b0}};
            end
        endcase
    end

    // Controls are forced low while reset is held so nothing moves during reset
    always_comb begin
        pc_hold      = pc_hold_s      & ~reset;
        f_stall      = f_stall_s      & ~reset;
        d_hold       = d_hold_s       & ~reset;
        e_bubble     = e_bubble_s     & ~reset;
        e_hold       = e_hold_s       & ~reset;
        m_bubble     = m_bubble_s     & ~reset;
        icache_abort = icache_abort_s & ~reset;
        ctrl_state   = state_q;
        stall_count  = stall_count_q;
    end

    // Stall counter: free-running wrap at 2^32
    always_comb begin
        if (pc_hold) begin
            stall_count_d = stall_count_q + 32'd1;
        end else begin
            stall_count_d = stall_count_q;
        end
    end

    // State, multiply countdown and stall counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= S_RUN;
            mul_cnt_q     <= {CNT_W{1'b0}};
            stall_count_q <= 32'd0;
        end else begin
            state_q       <= state_d;
            mul_cnt_q     <= mul_cnt_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It drives the fetch-to-decode register's f_stall input and the hold/bubble controls of the later pipeline registers. It resolves load-use hazards, I-cache and D-cache miss waits, multi-cycle multiply occupancy and taken-branch squashes. It also keeps a stall-cycle performance counter.

Parameters:
MUL_LATENCY, 4, total execute-stage cycles of a multiply (legal range 2..16)
REG_W, 5, register-address width

Ports:
clock  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
d_rs  input  REG_W  decode-stage source register 1
d_rt  input  REG_W  decode-stage source register 2
d_uses_rs  input  1  decode instruction reads d_rs
d_uses_rt  input  1  decode instruction reads d_rt
e_rd  input  REG_W  execute-stage destination register
e_mem_read  input  1  execute-stage instruction is a load
e_branch_taken  input  1  execute-stage branch/jump resolved taken
e_mul_start  input  1  multiply entered execute this cycle
icache_miss  input  1  fetch missed in I-cache
icache_ready  input  1  I-cache refill done; instruction valid this cycle
dcache_miss  input  1  memory-stage access missed
dcache_ready  input  1  D-cache refill done; data valid this cycle
pc_hold  output  1  hold PC
f_stall  output  1  to fetch_to_decode; inserts NOP into decode
d_hold  output  1  hold decode/execute register contents
e_bubble  output  1  insert NOP into execute
e_hold  output  1  hold execute/memory register
m_bubble  output  1  insert NOP into writeback
icache_abort  output  1  cancel outstanding I-cache refill
ctrl_state  output  2  0=RUN 1=IWAIT 2=DWAIT 3=MULBUSY
stall_count  output  32  cycles with pc_hold=1 since reset

Behaviour:
- Reset (async):
  - state=RUN, mul counter=0, stall_count=0.
  - All outputs are decoded combinationally from state and inputs, so every output is 0 while reset is asserted.
- Transitions out of RUN (priority dcache_miss > e_mul_start > icache_miss):
  - dcache_miss -> DWAIT.
  - e_mul_start -> MULBUSY; counter loads MUL_LATENCY-1.
  - icache_miss -> IWAIT.
  - Otherwise stay in RUN.
- Load-use hazard, evaluated in RUN only, with no transition pending:
  - Condition: e_mem_read & e_rd!=0 & ((d_uses_rs & d_rs==e_rd) | (d_uses_rt & d_rt==e_rd)).
  - Action: pc_hold=1, d_hold=1, e_bubble=1 for that cycle.
  - Lasts exactly 1 cycle, because the load advances.
- Taken branch in RUN (e_branch_taken=1): f_stall=1, e_bubble=1; pc_hold=0 so the redirect PC loads.
  - Branch overrides a simultaneous load-use result; the two are architecturally exclusive.
  - Branch also overrides the icache_miss transition: stay in RUN and assert icache_abort=1.
- Outputs in the cycle a transition out of RUN is taken: the outputs of the destination state.
- IWAIT:
  - Asserted: pc_hold=1, f_stall=1. Back stages run (d_hold=e_hold=0).
  - icache_ready -> RUN; in that cycle pc_hold=0 and f_stall=0, so the instruction is accepted.
  - e_branch_taken -> icache_abort=1, f_stall=1, e_bubble=1, pc_hold=0, next=RUN. Branch wins over a simultaneous icache_ready.
  - dcache_miss -> DWAIT, highest priority.
- DWAIT:
  - Asserted: pc_hold=1, d_hold=1, e_hold=1, m_bubble=1.
  - dcache_ready -> RUN; all holds=0 in the ready cycle.
  - A pending I-cache miss is re-detected in RUN via icache_miss, which the I-cache holds high.
- MULBUSY:
  - Asserted: pc_hold=1, d_hold=1, e_hold=1, m_bubble=1. Counter decrements each cycle.
  - When counter==0: holds=0, next=RUN.
  - Total stall = MUL_LATENCY-1 cycles beyond the entry cycle.
  - dcache_miss during MULBUSY is deferred until RUN; the memory stage is bubbled, so it cannot occur.
- stall_count: increments on every cycle with pc_hold=1 and wraps at 2^32-1 -> 0.
- Reset mid-state returns to RUN immediately. An outstanding refill is not aborted by this block.

Test Plan:
- Load-use: e_mem_read=1, e_rd=5, d_rs=5, d_uses_rs=1 -> exactly 1 cycle of pc_hold=d_hold=e_bubble=1; stall_count=1. Repeat with e_rd=0 -> no stall.
- I-miss: icache_miss for 1 cycle, icache_ready 6 cycles later -> ctrl_state=1 for 6 cycles with f_stall=pc_hold=1; ready cycle f_stall=0; stall_count=6.
- Branch in IWAIT: enter IWAIT, assert e_branch_taken together with icache_ready -> icache_abort=1, f_stall=1, e_bubble=1, pc_hold=0, next state RUN.
- Multiply with MUL_LATENCY=4: e_mul_start -> ctrl_state=3 for 4 cycles, holds high for the first 3 and low in the 4th, then RUN.
- Priority: dcache_miss, e_mul_start and icache_miss asserted together in RUN -> DWAIT. After dcache_ready, with icache_miss still high -> IWAIT.
- Async reset asserted mid-DWAIT, between clock edges -> outputs 0 and ctrl_state=0 immediately; stall_count=0.
- Counter wrap: force stall_count to 0xFFFFFFFF, one stall cycle -> 0.
